uart_tx_arbiter: RTL

- Shares the single UART transmit byte channel among NUM_REQ requesters, e.g. the CPU MMIO path, a debug monitor and a boot/log streamer.
- Arbitration is round-robin, at message granularity: a granted requester keeps the channel until it sends a byte flagged last, so messages never interleave.
- Sits between the requesters and the uart_tx valid/ready byte interface. A hold timeout stops a stalled owner from locking the channel forever.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter in front of one UART tx byte channel
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 1024,
    parameter int CW       = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_data_valid,
    input  logic                         tx_data_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         lock_abort
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic            last_flag;
    logic [CW-1:0]   hold_cnt;

    logic [7:0]      req_byte [NUM_REQ];
    logic [IW-1:0]   scan_idx [NUM_REQ];
    logic [IW-1:0]   winner;
    logic            winner_found;
    logic [IW-1:0]   cap_id;
    logic            accept;
    logic            hold_expire;

    // Split the flat data bus into one byte per requester
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotating scan order: the requester after last_grant comes first
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx[k] = IW'((int'(last_grant) + k + 1) % NUM_REQ);
        end
    end

    // First valid requester in the rotating order wins the idle channel
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!winner_found && req_valid[scan_idx[k]]) begin
                winner_found = 1'b1;
                winner       = scan_idx[k];
            end
        end
    end

    // Accept strobes: winner in IDLE, current owner only in HOLD, nobody while a byte is in flight
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (winner_found) begin
                        req_ready[winner] = 1'b1;
                        accept            = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (req_valid[grant_id]) begin
                        req_ready[grant_id] = 1'b1;
                        accept              = 1'b1;
                    end
                end
                default: begin
                    req_ready = '0;
                    accept    = 1'b0;
                end
            endcase
        end
    end

    assign cap_id      = (state == ST_HOLD) ? grant_id : winner;
    assign hold_expire = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
    assign busy        = (state != ST_IDLE);

    // Channel ownership FSM with the registered byte stage toward uart_tx
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            last_grant    <= IW'(NUM_REQ - 1);
            last_flag     <= 1'b0;
            hold_cnt      <= '0;
            lock_abort    <= 1'b0;
        end else begin
            lock_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data       <= req_byte[cap_id];
                        tx_data_valid <= 1'b1;
                        grant_id      <= cap_id;
                        last_flag     <= req_last[cap_id];
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_data_ready) begin
                        tx_data_valid <= 1'b0;
                        if (last_flag) begin
                            last_grant <= grant_id;
                            state      <= ST_IDLE;
                        end else begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        // A byte arriving on the expiry cycle still wins over the abort
                        tx_data       <= req_byte[cap_id];
                        tx_data_valid <= 1'b1;
                        last_flag     <= req_last[cap_id];
                        hold_cnt      <= '0;
                        state         <= ST_SEND;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_expire) begin
                            last_grant <= grant_id;
                            lock_abort <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
